// File: rtl/AHB_pkg.sv
// Shared AHB-Lite encodings, field widths and the transfer legality check
// used by the SRAM slave.
package AHB_pkg;

    localparam int unsigned HTRANS_W = 2;
    localparam int unsigned HSIZE_W  = 3;
    localparam int unsigned HBURST_W = 3;
    localparam int unsigned HPROT_W  = 4;
    localparam int unsigned WAIT_W   = 4;

    typedef enum logic [HTRANS_W-1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } HTRANS_e;

    typedef enum logic [HSIZE_W-1:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3,
        SIZE_4W    = 3'd4,
        SIZE_8W    = 3'd5,
        SIZE_16W   = 3'd6,
        SIZE_32W   = 3'd7
    } HSIZE_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } HRESP_e;

    // Transfer is illegal if it lands past the storage, is wider than the
    // data bus, or is not naturally aligned to its own size.
    function automatic logic xfer_err(input logic [63:0]         addr,
                                      input logic [HSIZE_W-1:0]  size,
                                      input int unsigned         log2_bytes,
                                      input int unsigned         depth);
        logic [63:0] mask;
        mask     = (64'd1 << size) - 64'd1;
        xfer_err = ((addr >> log2_bytes) >= 64'(depth)) ||
                   (32'(size) > log2_bytes) ||
                   ((addr & mask) != 64'd0);
    endfunction

endpackage

// File: rtl/ahb_lite_sram_array.sv
// Word-organised storage with per-byte write enables and asynchronous read.
// Ports: clk, we (write strobe), be (byte lanes), addr (word index),
//        wdata (write word), rdata (word at addr, combinational).
module ahb_lite_sram_array #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IDX_W-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write; lanes without an enable keep their contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and two-cycle ERROR
// response for out-of-range, oversized or misaligned transfers.
// Ports: clk, HRESET (async, active-high), AHB-Lite slave inputs HSEL,
//        HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA, HREADY;
//        outputs HREADYOUT, HRESP (registered) and HRDATA.
module ahb_lite_sram_slave
    import AHB_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [HTRANS_W-1:0]   HTRANS,
    input  logic [HSIZE_W-1:0]    HSIZE,
    input  logic [HBURST_W-1:0]   HBURST,
    input  logic [HPROT_W-1:0]    HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int unsigned NBYTES     = DATA_WIDTH / 8;
    localparam int unsigned LOG2_BYTES = $clog2(NBYTES);
    localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

    state_e                state, state_nxt;
    logic [WAIT_W-1:0]     wait_cnt, wait_cnt_nxt;
    logic                  ready_nxt;
    logic                  resp_nxt;

    logic                  d_valid;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    HSIZE_e                d_size;

    logic                  accept;
    logic                  acc_err;
    logic                  mem_we;
    logic [NBYTES-1:0]     mem_be;
    logic [ADDR_WIDTH-1:0] lane_off;
    logic [ADDR_WIDTH-1:0] lane_end;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  unused_ok;
    assign unused_ok = ^{HBURST, HPROT};

    // New address phase only while this slave is not stalling the bus.
    assign accept  = HSEL && HREADY && HREADYOUT &&
                     ((HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ));
    assign acc_err = xfer_err(64'(HADDR), HSIZE, LOG2_BYTES, DEPTH);

    // Next-state and registered-output values.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ready_nxt    = 1'b1;
        resp_nxt     = RESP_OKAY;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (acc_err) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = WAIT_W'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                if (wait_cnt <= WAIT_W'(1)) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
        case (state_nxt)
            ST_WAIT: ready_nxt = 1'b0;
            ST_ERR1: begin
                ready_nxt = 1'b0;
                resp_nxt  = RESP_ERROR;
            end
            ST_ERR2: resp_nxt = RESP_ERROR;
            default: ready_nxt = 1'b1;
        endcase
    end

    // State, outputs and data-phase context.
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= RESP_OKAY;
            d_valid   <= 1'b0;
            d_write   <= 1'b0;
            d_addr    <= '0;
            d_size    <= SIZE_BYTE;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            HREADYOUT <= ready_nxt;
            HRESP     <= resp_nxt;
            if (HREADYOUT) begin
                d_valid <= accept && !acc_err;
                if (accept) begin
                    d_write <= HWRITE;
                    d_addr  <= HADDR;
                    d_size  <= HSIZE_e'(HSIZE);
                end
            end
        end
    end

    // Byte lanes covered by the registered transfer.
    always_comb begin
        lane_off = d_addr & ADDR_WIDTH'(NBYTES - 1);
        lane_end = lane_off + (ADDR_WIDTH'(1) << d_size);
        mem_be   = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            mem_be[i] = (ADDR_WIDTH'(i) >= lane_off) && (ADDR_WIDTH'(i) < lane_end);
        end
    end

    // d_valid only survives to a ready cycle for OKAY transfers.
    assign mem_we = d_valid && d_write && HREADYOUT && !HRESET;
    assign HRDATA = (d_valid && !d_write && HREADYOUT) ? mem_rdata : '0;

    ahb_lite_sram_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (IDX_W'(d_addr >> LOG2_BYTES)),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomized and directed bench for two slaves (0 and 3 wait states),
// checked cycle by cycle against a transaction-level bus/memory model.
module tb_ahb_lite_sram_slave;

    localparam int WS [2] = '{0, 3};

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic              clk = 1'b0;
    logic [1:0]        hreset;
    logic [1:0]        hsel;
    logic [1:0]        hwrite;
    logic [1:0][31:0]  haddr;
    logic [1:0][1:0]   htrans;
    logic [1:0][2:0]   hsize;
    logic [1:0][31:0]  hwdata;
    logic [1:0]        hreadyout;
    logic [1:0]        hresp;
    logic [1:0][31:0]  hrdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    xfer_t       q[$];
    logic [31:0] mdl [2][256];

    always #5 clk = ~clk;

    ahb_lite_sram_slave #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HWRITE(hwrite[0]), .HTRANS(htrans[0]), .HSIZE(hsize[0]),
        .HBURST(3'b001), .HPROT(4'b0011), .HWDATA(hwdata[0]),
        .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]),
        .HRDATA(hrdata[0])
    );

    ahb_lite_sram_slave #(.WAIT_STATES(3)) u_dut1 (
        .clk(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HWRITE(hwrite[1]), .HTRANS(htrans[1]), .HSIZE(hsize[1]),
        .HBURST(3'b001), .HPROT(4'b0011), .HWDATA(hwdata[1]),
        .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]),
        .HRDATA(hrdata[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata);
        xfer_t t;
        t.sel = sel; t.trans = trans; t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata;
        return t;
    endfunction

    // Slave is addressed with an active transfer.
    function automatic bit is_act(input xfer_t t);
        return t.sel && (t.trans == 2'b10 || t.trans == 2'b11);
    endfunction

    // 256 words of 4 bytes; size at most a word; naturally aligned.
    function automatic bit is_err(input xfer_t t);
        return (t.addr / 4 >= 256) || (t.size > 3'd2) || ((t.addr % (32'd1 << t.size)) != 0);
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t t;
        int unsigned k, word, off;
        k       = $urandom_range(0, 9);
        t.sel   = ($urandom_range(0, 7) != 0);
        t.trans = (k < 1) ? 2'b00 : (k < 2) ? 2'b01 : (k < 6) ? 2'b10 : 2'b11;
        t.wr    = 1'($urandom_range(0, 1));
        t.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        word    = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 31);
        off     = $urandom_range(0, 3);
        if ($urandom_range(0, 7) != 0) off = off & ~((32'd1 << t.size) - 1);
        t.addr  = word * 4 + off;
        if ($urandom_range(0, 19) == 0) t.addr = 32'h400 + 4 * $urandom_range(0, 63);
        t.wdata = $urandom;
        return t;
    endfunction

    // Drive every queued transfer to slave d with AHB pipelining, checking
    // HREADYOUT/HRESP/HRDATA each cycle against the model.
    task automatic run(input int d);
        xfer_t       pend;
        xfer_t       idle_x;
        bit          pend_act, pend_err, exp_ready, exp_resp;
        logic [31:0] exp_rd;
        int unsigned off, nb;
        int          dcyc, guard;
        idle_x   = mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
        pend     = idle_x;
        pend_act = 0;
        pend_err = 0;
        dcyc     = 0;
        guard    = 0;
        while ((q.size() > 0 || pend_act) && guard < 5000) begin
            guard++;
            @(negedge clk);
            hwdata[d] = pend.wdata;
            if (!pend_act) begin
                exp_ready = 1; exp_resp = 0;
            end else if (pend_err) begin
                exp_ready = (dcyc >= 1); exp_resp = 1;
            end else begin
                exp_ready = (dcyc >= WS[d]); exp_resp = 0;
            end
            exp_rd = 32'h0;
            if (pend_act && !pend_err && !pend.wr && exp_ready) exp_rd = mdl[d][pend.addr / 4];
            check_eq($sformatf("dut%0d_hreadyout", d), 64'(hreadyout[d]), 64'(exp_ready));
            check_eq($sformatf("dut%0d_hresp", d), 64'(hresp[d]), 64'(exp_resp));
            check_eq($sformatf("dut%0d_hrdata@%h", d, pend.addr), 64'(hrdata[d]), 64'(exp_rd));
            if (exp_ready) begin
                if (pend_act && !pend_err && pend.wr) begin
                    off = pend.addr % 4;
                    nb  = 32'd1 << pend.size;
                    for (int b = 0; b < 4; b++) begin
                        if (b >= int'(off) && b < int'(off + nb))
                            mdl[d][pend.addr / 4][8*b +: 8] = pend.wdata[8*b +: 8];
                    end
                end
                pend      = (q.size() > 0) ? q.pop_front() : idle_x;
                hsel[d]   = pend.sel;
                htrans[d] = pend.trans;
                hwrite[d] = pend.wr;
                haddr[d]  = pend.addr;
                hsize[d]  = pend.size;
                pend_act  = is_act(pend);
                pend_err  = pend_act && is_err(pend);
                dcyc      = 0;
            end else begin
                dcyc++;
            end
        end
        if (guard >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d_run_timeout: got %0d cycles expected under 5000", d, guard);
        end
    endtask

    task automatic load_directed();
        q.push_back(mk(1, 2'b10, 1, 32'h10,  3'd2, 32'hDEADBEEF));
        q.push_back(mk(1, 2'b10, 0, 32'h10,  3'd2, 32'h0));
        q.push_back(mk(1, 2'b10, 1, 32'h10,  3'd2, 32'h11223344));
        q.push_back(mk(1, 2'b10, 1, 32'h13,  3'd0, 32'hAA000000));
        q.push_back(mk(1, 2'b10, 0, 32'h10,  3'd2, 32'h0));
        q.push_back(mk(1, 2'b10, 1, 32'h11,  3'd1, 32'h5555AAAA));
        q.push_back(mk(1, 2'b10, 0, 32'h400, 3'd2, 32'h0));
        q.push_back(mk(1, 2'b10, 0, 32'h10,  3'd2, 32'h0));
        q.push_back(mk(1, 2'b10, 1, 32'h3FC, 3'd2, 32'hCAFEF00D));
        q.push_back(mk(1, 2'b10, 0, 32'h3FC, 3'd2, 32'h0));
        q.push_back(mk(1, 2'b10, 1, 32'h20,  3'd2, 32'hA0A0A0A0));
        q.push_back(mk(1, 2'b01, 1, 32'h24,  3'd2, 32'hFFFFFFFF));
        q.push_back(mk(1, 2'b11, 1, 32'h24,  3'd2, 32'hB1B1B1B1));
        q.push_back(mk(1, 2'b00, 0, 32'h28,  3'd2, 32'h0));
        q.push_back(mk(1, 2'b11, 1, 32'h28,  3'd2, 32'hC2C2C2C2));
        q.push_back(mk(1, 2'b01, 0, 32'h2C,  3'd2, 32'h0));
        q.push_back(mk(1, 2'b11, 0, 32'h20,  3'd2, 32'h0));
        q.push_back(mk(1, 2'b00, 1, 32'h24,  3'd2, 32'h12345678));
        q.push_back(mk(1, 2'b11, 0, 32'h24,  3'd2, 32'h0));
        q.push_back(mk(1, 2'b11, 0, 32'h28,  3'd2, 32'h0));
        q.push_back(mk(0, 2'b10, 1, 32'h28,  3'd2, 32'h0BADBAD0));
        q.push_back(mk(1, 2'b10, 0, 32'h28,  3'd2, 32'h0));
    endtask

    initial begin
        hreset = 2'b11;
        hsel   = '0; hwrite = '0; haddr = '0; htrans = '0; hsize = '0; hwdata = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("dut%0d_rst_hreadyout", d), 64'(hreadyout[d]), 64'd1);
            check_eq($sformatf("dut%0d_rst_hresp", d), 64'(hresp[d]), 64'd0);
            check_eq($sformatf("dut%0d_rst_hrdata", d), 64'(hrdata[d]), 64'd0);
        end
        hreset = 2'b00;

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 32; w++) q.push_back(mk(1, 2'b10, 1, 32'(w * 4), 3'd2, $urandom));
            q.push_back(mk(1, 2'b10, 1, 32'h3FC, 3'd2, $urandom));
            run(d);
            load_directed();
            run(d);
            for (int i = 0; i < 150; i++) q.push_back(rand_xfer());
            run(d);
        end

        // Reset during the wait phase of a write aborts it.
        @(negedge clk);
        hsel[1] = 1; htrans[1] = 2'b10; hwrite[1] = 1; haddr[1] = 32'h40; hsize[1] = 3'd2;
        @(negedge clk);
        hwdata[1] = ~mdl[1][16];
        hsel[1]   = 0; htrans[1] = 2'b00;
        check_eq("dut1_abort_waiting", 64'(hreadyout[1]), 64'd0);
        hreset[1] = 1'b1;
        #1;
        check_eq("dut1_abort_hreadyout", 64'(hreadyout[1]), 64'd1);
        check_eq("dut1_abort_hresp", 64'(hresp[1]), 64'd0);
        check_eq("dut1_abort_hrdata", 64'(hrdata[1]), 64'd0);
        @(negedge clk);
        hreset[1] = 1'b0;
        q.push_back(mk(1, 2'b10, 0, 32'h40, 3'd2, 32'h0));
        run(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
